// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and frame geometry.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted stream bytes big-endian into 32-bit words; word is valid with the 4th byte.
module byte_assembler
  import imem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_cnt;
  logic [23:0] r_shift;

  // The 4th byte is forwarded combinationally so the loader can register the word in one step.
  assign o_word_valid = i_byte_en && (r_cnt == 2'(BYTES_PER_WORD - 1));
  assign o_word       = {r_shift, i_byte};

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_byte_en) begin
      r_cnt <= r_cnt + 2'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_byte_en) begin
      r_shift <= {r_shift[15:0], i_byte};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Fills IMEM from a length-prefixed, XOR-checksummed byte stream and holds the core until verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [DATA_W-1:0] im_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_written
);

  localparam int unsigned MAX_WORDS = 1 << ADDR_W;

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_start_load;
  logic              w_byte_en;
  logic [15:0]       w_len;
  logic              w_last_word;
  logic [31:0]       w_word;
  logic              w_word_valid;

  logic [15:0]       r_len;
  logic [7:0]        r_csum;
  logic [ADDR_W:0]   r_words;
  logic              r_done;
  logic              r_error;
  logic              r_hold;
  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_addr_p1;
  logic [DATA_W-1:0] r_wdata_p1;

  assign in_ready = (r_state == ST_LEN_HI) || (r_state == ST_LEN_LO) ||
                    (r_state == ST_DATA)   || (r_state == ST_CSUM);
  assign w_accept    = in_valid && in_ready;
  assign w_byte_en   = w_accept && (r_state == ST_DATA);
  assign w_len       = {r_len[7:0], in_data};
  // r_words still holds the index of the word completing this cycle.
  assign w_last_word = (17'(r_words) + 17'd1) == {1'b0, r_len};

  byte_assembler u_asm (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clr        (w_start_load),
    .i_byte_en    (w_byte_en),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_start_load = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          w_next       = ST_LEN_HI;
          w_start_load = 1'b1;
        end
      end
      ST_LEN_HI: if (w_accept) w_next = ST_LEN_LO;
      ST_LEN_LO: begin
        if (w_accept) begin
          if (32'(w_len) > MAX_WORDS) w_next = ST_ERR;
          else if (w_len == 16'd0)    w_next = ST_CSUM;
          else                        w_next = ST_DATA;
        end
      end
      ST_DATA:   if (w_word_valid && w_last_word) w_next = ST_CSUM;
      ST_CSUM:   if (w_accept) w_next = (in_data == r_csum) ? ST_DONE : ST_ERR;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Stage p1: word commit, status flags and counters registered on the accepting edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len      <= '0;
      r_csum     <= '0;
      r_words    <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_hold     <= 1'b1;
      r_vld_p1   <= 1'b0;
      r_addr_p1  <= '0;
      r_wdata_p1 <= '0;
    end else begin
      r_vld_p1 <= w_word_valid;
      r_done   <= (w_next == ST_DONE);
      r_error  <= (w_next == ST_ERR);
      r_hold   <= (w_next != ST_DONE);
      if (w_accept && ((r_state == ST_LEN_HI) || (r_state == ST_LEN_LO))) begin
        r_len <= w_len;
      end
      if (w_start_load) begin
        r_words   <= '0;
        r_addr_p1 <= '0;
        r_csum    <= '0;
      end else begin
        if (w_byte_en) begin
          r_csum <= r_csum ^ in_data;
        end
        if (w_word_valid) begin
          r_addr_p1  <= r_words[ADDR_W-1:0];
          r_wdata_p1 <= DATA_W'(w_word);
          r_words    <= r_words + 1'b1;
        end
      end
    end
  end

  assign im_we         = r_vld_p1;
  assign im_addr       = r_addr_p1;
  assign im_wdata      = r_wdata_p1;
  assign words_written = r_words;
  assign done          = r_done;
  assign error         = r_error;
  assign cpu_hold      = r_hold;

endmodule
